// File: rtl/vga_text_console.sv
// rtl/vga_text_console.sv - cursor/fill sequencer driving the 80x60 text map RAM write port
// Optional tab expansion is compiled in when CONSOLE_TAB_EN is defined.
module vga_text_console #(
  parameter int          COLS      = 80,
  parameter int          ROWS      = 60,
  parameter logic [7:0]  FILL_CHAR = 8'h20,
  parameter int          TAB_WIDTH = 8
) (
  input  logic        CLK_50M,
  input  logic        RESET_N,
  input  logic        ch_valid,
  input  logic [7:0]  ch_data,
  output logic        ch_ready,
  output logic [12:0] mem_addr,
  output logic        mem_we_v,
  output logic [7:0]  b,
  output logic [5:0]  cursor_row,
  output logic [6:0]  cursor_col
);

`ifdef CONSOLE_TAB_EN
  typedef enum logic [1:0] {INIT_CLEAR, IDLE, LINE_CLEAR, TAB} state_t;
  localparam logic [6:0] TAB_MASK = 7'(TAB_WIDTH - 1);
`else
  typedef enum logic [1:0] {INIT_CLEAR, IDLE, LINE_CLEAR} state_t;
`endif

  localparam logic [6:0] LAST_COL = 7'(COLS - 1);
  localparam logic [5:0] LAST_ROW = 6'(ROWS - 1);

  state_t      state, state_n;
  logic [5:0]  row_n, frow, frow_n;
  logic [6:0]  col_n, fcol, fcol_n;
  logic [6:0]  col_inc, col_dec;
  logic [5:0]  row_wrap;
  logic [12:0] addr_n;
  logic [7:0]  b_n;
  logic        we_n, ready_n, accept;

  assign col_inc  = cursor_col + 7'd1;
  assign col_dec  = cursor_col - 7'd1;
  assign row_wrap = (cursor_row == LAST_ROW) ? 6'd0 : cursor_row + 6'd1;
  assign accept   = ch_valid && ch_ready;

  always_comb begin
    state_n = state;
    row_n   = cursor_row;
    col_n   = cursor_col;
    frow_n  = frow;
    fcol_n  = fcol;
    we_n    = 1'b0;
    addr_n  = mem_addr;
    b_n     = b;
    case (state)
      INIT_CLEAR: begin
        we_n   = 1'b1;
        addr_n = {frow, fcol};
        b_n    = FILL_CHAR;
        row_n  = 6'd0;
        col_n  = 7'd0;
        if (fcol == LAST_COL) begin
          fcol_n = 7'd0;
          if (frow == LAST_ROW) begin
            frow_n  = 6'd0;
            state_n = IDLE;
          end else begin
            frow_n = frow + 6'd1;
          end
        end else begin
          fcol_n = fcol + 7'd1;
        end
      end
      IDLE: begin
        if (accept) begin
          case (ch_data)
            8'h0A: begin
              row_n   = row_wrap;
              col_n   = 7'd0;
              fcol_n  = 7'd0;
              state_n = LINE_CLEAR;
            end
            8'h0D: col_n = 7'd0;
            8'h08: begin
              if (cursor_col != 7'd0) begin
                col_n  = col_dec;
                we_n   = 1'b1;
                addr_n = {cursor_row, col_dec};
                b_n    = FILL_CHAR;
              end
            end
            8'h0C: begin
              row_n   = 6'd0;
              col_n   = 7'd0;
              frow_n  = 6'd0;
              fcol_n  = 7'd0;
              state_n = INIT_CLEAR;
            end
`ifdef CONSOLE_TAB_EN
            8'h09: state_n = TAB;
`endif
            default: begin
              we_n   = 1'b1;
              addr_n = {cursor_row, cursor_col};
              b_n    = ch_data;
              // Writing the last column wraps to a freshly cleared next line.
              if (cursor_col == LAST_COL) begin
                row_n   = row_wrap;
                col_n   = 7'd0;
                fcol_n  = 7'd0;
                state_n = LINE_CLEAR;
              end else begin
                col_n = col_inc;
              end
            end
          endcase
        end
      end
      LINE_CLEAR: begin
        we_n   = 1'b1;
        addr_n = {cursor_row, fcol};
        b_n    = FILL_CHAR;
        if (fcol == LAST_COL) begin
          fcol_n  = 7'd0;
          state_n = IDLE;
        end else begin
          fcol_n = fcol + 7'd1;
        end
      end
`ifdef CONSOLE_TAB_EN
      TAB: begin
        we_n   = 1'b1;
        addr_n = {cursor_row, cursor_col};
        b_n    = FILL_CHAR;
        if (cursor_col == LAST_COL) begin
          row_n   = row_wrap;
          col_n   = 7'd0;
          fcol_n  = 7'd0;
          state_n = LINE_CLEAR;
        end else begin
          col_n = col_inc;
          if ((col_inc & TAB_MASK) == 7'd0) state_n = IDLE;
        end
      end
`endif
      default: state_n = IDLE;
    endcase
    // Hold off new bytes until the final cell write of a sequence is on the port.
    ready_n = (state_n == IDLE) && !we_n;
  end

  always_ff @(posedge CLK_50M or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= INIT_CLEAR;
      cursor_row <= 6'd0;
      cursor_col <= 7'd0;
      frow       <= 6'd0;
      fcol       <= 7'd0;
      mem_we_v   <= 1'b0;
      mem_addr   <= 13'd0;
      b          <= FILL_CHAR;
      ch_ready   <= 1'b0;
    end else begin
      state      <= state_n;
      cursor_row <= row_n;
      cursor_col <= col_n;
      frow       <= frow_n;
      fcol       <= fcol_n;
      mem_we_v   <= we_n;
      mem_addr   <= addr_n;
      b          <= b_n;
      ch_ready   <= ready_n;
    end
  end

endmodule

// File: tb/tb_vga_text_console.sv
// tb/tb_vga_text_console.sv - scoreboard bench for vga_text_console
module tb_vga_text_console;
  logic        CLK_50M = 1'b0;
  logic        RESET_N = 1'b0;
  logic        ch_valid = 1'b0;
  logic [7:0]  ch_data = 8'h00;
  logic        ch_ready, mem_we_v;
  logic [12:0] mem_addr;
  logic [7:0]  b;
  logic [5:0]  cursor_row;
  logic [6:0]  cursor_col;

  vga_text_console dut (
    .CLK_50M(CLK_50M), .RESET_N(RESET_N), .ch_valid(ch_valid), .ch_data(ch_data),
    .ch_ready(ch_ready), .mem_addr(mem_addr), .mem_we_v(mem_we_v), .b(b),
    .cursor_row(cursor_row), .cursor_col(cursor_col)
  );

  always #10 CLK_50M = ~CLK_50M;

  logic [20:0] exp_q[$];
  int pass_cnt = 0, chk_cnt = 0, wr_cnt = 0;
  int m_row = 0, m_col = 0;

  // Monitor: every cell write must match the head of the expected queue.
  initial begin
    logic [20:0] e;
    forever begin
      @(negedge CLK_50M);
      if (RESET_N && mem_we_v) begin
        wr_cnt++;
        chk_cnt++;
        if (exp_q.size() == 0) begin
          $display("FAIL write_unexpected got addr=%h b=%h required no write", mem_addr, b);
        end else begin
          e = exp_q.pop_front();
          if ({mem_addr, b} === e) pass_cnt++;
          else $display("FAIL write got addr=%h b=%h required addr=%h b=%h",
                        mem_addr, b, e[20:8], e[7:0]);
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s got %0d required %0d", name, act, exp);
  endtask

  task automatic push_w(input int r, input int c, input logic [7:0] d);
    exp_q.push_back({6'(r), 7'(c), d});
  endtask

  task automatic push_row_fill(input int r);
    for (int c = 0; c < 80; c++) push_w(r, c, 8'h20);
  endtask

  task automatic push_full();
    for (int r = 0; r < 60; r++) push_row_fill(r);
  endtask

  task automatic send_raw(input logic [7:0] d);
    int n = 0;
    @(negedge CLK_50M);
    ch_data = d;
    ch_valid = 1'b1;
    while (!ch_ready && n < 20000) begin
      @(negedge CLK_50M);
      n++;
    end
    if (n >= 20000) begin
      chk_cnt++;
      $display("FAIL send_timeout got ch_ready=0 required ch_ready=1");
    end
    @(posedge CLK_50M);
    #1 ch_valid = 1'b0;
  endtask

  task automatic wait_ready(output int lows);
    lows = 0;
    @(negedge CLK_50M);
    while (!ch_ready && lows < 20000) begin
      lows++;
      @(negedge CLK_50M);
    end
    if (lows >= 20000) begin
      chk_cnt++;
      $display("FAIL ready_timeout got ch_ready=0 required ch_ready=1");
    end
  endtask

  task automatic model_nl();
    m_row = (m_row == 59) ? 0 : m_row + 1;
    m_col = 0;
    push_row_fill(m_row);
  endtask

  // Setup sender: expectations come from a behavioural cursor model.
  task automatic send(input logic [7:0] d);
    send_raw(d);
    case (d)
      8'h0A: model_nl();
      8'h0D: m_col = 0;
      8'h08: if (m_col != 0) begin m_col--; push_w(m_row, m_col, 8'h20); end
      8'h0C: begin push_full(); m_row = 0; m_col = 0; end
      default: begin
        push_w(m_row, m_col, d);
        if (m_col == 79) model_nl(); else m_col++;
      end
    endcase
  endtask

  task automatic check_cursor(input string name, input int r, input int c);
    check({name, "_row"}, int'(cursor_row), r);
    check({name, "_col"}, int'(cursor_col), c);
    check({name, "_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    int lows, w0;
    repeat (3) @(negedge CLK_50M);
    check("rst_we", int'(mem_we_v), 0);
    check("rst_addr", int'(mem_addr), 0);
    check("rst_b", int'(b), 8'h20);
    check("rst_ready", int'(ch_ready), 0);
    check("rst_row", int'(cursor_row), 0);
    check("rst_col", int'(cursor_col), 0);

    push_full();
    w0 = wr_cnt;
    RESET_N = 1'b1;
    wait_ready(lows);
    check("init_writes", wr_cnt - w0, 4800);
    check_cursor("init", 0, 0);

    send_raw(8'h41);
    push_w(0, 0, 8'h41);
    wait_ready(lows);
    check("a_ready_low", lows, 1);
    check_cursor("a", 0, 1);
    m_row = 0; m_col = 1;

    for (int i = 0; i < 5; i++) send(8'h0A);
    for (int i = 0; i < 79; i++) send(8'h61);
    wait_ready(lows);
    check_cursor("pre_wrap", 5, 79);
    send_raw(8'h42);
    push_w(5, 79, 8'h42);
    push_row_fill(6);
    wait_ready(lows);
    check("wrap_ready_low", lows, 81);
    check_cursor("wrap", 6, 0);
    m_row = 6; m_col = 0;

    for (int i = 0; i < 53; i++) send(8'h0A);
    for (int i = 0; i < 10; i++) send(8'h62);
    wait_ready(lows);
    check_cursor("pre_lf", 59, 10);
    send_raw(8'h0A);
    push_row_fill(0);
    wait_ready(lows);
    check_cursor("lf_wrap", 0, 0);
    m_row = 0; m_col = 0;

    for (int i = 0; i < 3; i++) send(8'h0A);
    wait_ready(lows);
    w0 = wr_cnt;
    send_raw(8'h08);
    wait_ready(lows);
    repeat (2) @(negedge CLK_50M);
    check("bs0_writes", wr_cnt - w0, 0);
    check_cursor("bs0", 3, 0);
    for (int i = 0; i < 4; i++) send(8'h63);
    send_raw(8'h08);
    push_w(3, 3, 8'h20);
    wait_ready(lows);
    check_cursor("bs", 3, 3);
    m_col = 3;
    send(8'h64);
    wait_ready(lows);
    w0 = wr_cnt;
    send_raw(8'h0D);
    wait_ready(lows);
    repeat (2) @(negedge CLK_50M);
    check("cr_writes", wr_cnt - w0, 0);
    check_cursor("cr", 3, 0);
    m_col = 0;

    send(8'h0C);
    send(8'h0A);
    send(8'h0A);
    for (int i = 0; i < 3; i++) send(8'h65);
    wait_ready(lows);
    check_cursor("pre_tab", 2, 3);
    send_raw(8'h09);
`ifdef CONSOLE_TAB_EN
    for (int c = 3; c < 8; c++) push_w(2, c, 8'h20);
    wait_ready(lows);
    check_cursor("tab", 2, 8);
    m_col = 8;
`else
    push_w(2, 3, 8'h09);
    wait_ready(lows);
    check_cursor("tab_glyph", 2, 4);
    m_col = 4;
`endif

    send(8'h0A);
    repeat (10) @(negedge CLK_50M);
    check("mid_clear_we", int'(mem_we_v), 1);
    #3 RESET_N = 1'b0;
    #1 check("async_rst_we", int'(mem_we_v), 0);
    check("async_rst_ready", int'(ch_ready), 0);
    check("async_rst_row", int'(cursor_row), 0);
    exp_q.delete();
    @(negedge CLK_50M);
    push_full();
    w0 = wr_cnt;
    RESET_N = 1'b1;
    wait_ready(lows);
    check("reinit_writes", wr_cnt - w0, 4800);
    check_cursor("reinit", 0, 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
